// File: rtl/enemy_chaser.sv
// Per-tick enemy sweep: every enemy takes one step toward the player over a shared grid port.
// Define ENEMY_CHASER_DIAG_EN to try a diagonal step first when both axes differ.
module enemy_chaser #(
    parameter int GRID_W      = 40,
    parameter int GRID_H      = 30,
    parameter int X_BITS      = 6,
    parameter int Y_BITS      = 5,
    parameter int CELL_BITS   = 3,
    parameter int ENEMY_CODE  = 4,
    parameter int EMPTY_CODE  = 0,
    parameter int TICK_CYCLES = 200000
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     start,
    output logic                     done,
    output logic                     busy,
    input  logic [X_BITS-1:0]        player_x,
    input  logic [Y_BITS-1:0]        player_y,
    output logic [X_BITS-1:0]        grid_x,
    output logic [Y_BITS-1:0]        grid_y,
    input  logic [CELL_BITS-1:0]     grid_out,
    output logic                     grid_write,
    output logic [CELL_BITS-1:0]     grid_in,
    output logic [X_BITS+Y_BITS-1:0] moved_count
);

    localparam int TW = $clog2(TICK_CYCLES + 1);
    localparam int CW = X_BITS + Y_BITS;
    localparam int DW = (X_BITS > Y_BITS) ? X_BITS : Y_BITS;

    localparam logic [X_BITS-1:0]    X_MAX     = X_BITS'(GRID_W - 1);
    localparam logic [Y_BITS-1:0]    Y_MAX     = Y_BITS'(GRID_H - 1);
    localparam logic [X_BITS-1:0]    X_ONE     = X_BITS'(1);
    localparam logic [Y_BITS-1:0]    Y_ONE     = Y_BITS'(1);
    localparam logic [CW-1:0]        CNT_ONE   = CW'(1);
    localparam logic [TW-1:0]        TICK_ONE  = TW'(1);
    localparam logic [TW-1:0]        TICK_LAST = TW'(TICK_CYCLES - 1);
    localparam logic [CELL_BITS-1:0] ENEMY     = CELL_BITS'(ENEMY_CODE);
    localparam logic [CELL_BITS-1:0] EMPTY     = CELL_BITS'(EMPTY_CODE);

    typedef enum logic [3:0] {
        S_IDLE,
        S_RD_CUR,
        S_CHK_CUR,
        S_RD_TGT,
        S_CHK_TGT,
        S_WR_NEW,
        S_WR_OLD,
        S_ADV,
        S_DONE
    } state_t;

    state_t                  state_q, state_d;
    logic [TW-1:0]           tick_q, tick_d;
    logic                    pending_q, pending_d;
    logic [X_BITS-1:0]       cur_x_q, cur_x_d;
    logic [Y_BITS-1:0]       cur_y_q, cur_y_d;
    logic [X_BITS-1:0]       tgt_x_q, tgt_x_d;
    logic [Y_BITS-1:0]       tgt_y_q, tgt_y_d;
    logic [1:0][X_BITS-1:0]  alt_x_q, alt_x_d;
    logic [1:0][Y_BITS-1:0]  alt_y_q, alt_y_d;
    logic [1:0]              alt_v_q, alt_v_d;
    logic                    skip_q, skip_d;
    logic                    skip_nx_q, skip_nx_d;
    logic [GRID_W-1:0]       cur_mask_q, cur_mask_d;
    logic [GRID_W-1:0]       down_mask_q, down_mask_d;
    logic [CW-1:0]           tally_q, tally_d;
    logic [CW-1:0]           moved_q, moved_d;

    logic [X_BITS-1:0] px, adx, nx;
    logic [Y_BITS-1:0] py, ady, ny;
    logic              x_gt, x_lt, y_gt, y_lt;
    logic              x_mv, y_mv, pick_x;

    // Step direction and axis preference toward the clamped player position
    always_comb begin
        px     = (player_x > X_MAX) ? X_MAX : player_x;
        py     = (player_y > Y_MAX) ? Y_MAX : player_y;
        x_gt   = px > cur_x_q;
        x_lt   = px < cur_x_q;
        y_gt   = py > cur_y_q;
        y_lt   = py < cur_y_q;
        x_mv   = x_gt | x_lt;
        y_mv   = y_gt | y_lt;
        adx    = x_gt ? (px - cur_x_q) : (cur_x_q - px);
        ady    = y_gt ? (py - cur_y_q) : (cur_y_q - py);
        nx     = x_gt ? (cur_x_q + X_ONE) : (x_lt ? (cur_x_q - X_ONE) : cur_x_q);
        ny     = y_gt ? (cur_y_q + Y_ONE) : (y_lt ? (cur_y_q - Y_ONE) : cur_y_q);
        pick_x = DW'(adx) >= DW'(ady);
    end

    always_comb begin
        state_d     = state_q;
        tick_d      = (tick_q == '0) ? TICK_LAST : (tick_q - TICK_ONE);
        pending_d   = pending_q;
        cur_x_d     = cur_x_q;
        cur_y_d     = cur_y_q;
        tgt_x_d     = tgt_x_q;
        tgt_y_d     = tgt_y_q;
        alt_x_d     = alt_x_q;
        alt_y_d     = alt_y_q;
        alt_v_d     = alt_v_q;
        skip_d      = skip_q;
        skip_nx_d   = skip_nx_q;
        cur_mask_d  = cur_mask_q;
        down_mask_d = down_mask_q;
        tally_d     = tally_q;
        moved_d     = moved_q;

        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    if (pending_q) begin
                        pending_d   = 1'b0;
                        cur_x_d     = '0;
                        cur_y_d     = '0;
                        skip_d      = 1'b0;
                        skip_nx_d   = 1'b0;
                        cur_mask_d  = '0;
                        down_mask_d = '0;
                        tally_d     = '0;
                        state_d     = S_RD_CUR;
                    end else begin
                        state_d = S_DONE;
                    end
                end
            end
            S_RD_CUR: state_d = S_CHK_CUR;
            S_CHK_CUR: begin
                state_d = S_ADV;
                if (!skip_q && !cur_mask_q[cur_x_q] &&
                    grid_out == ENEMY && (x_mv || y_mv)) begin
                    state_d    = S_RD_TGT;
                    tgt_x_d    = pick_x ? nx : cur_x_q;
                    tgt_y_d    = pick_x ? cur_y_q : ny;
                    alt_x_d[0] = pick_x ? cur_x_q : nx;
                    alt_y_d[0] = pick_x ? ny : cur_y_q;
                    alt_x_d[1] = cur_x_q;
                    alt_y_d[1] = cur_y_q;
                    alt_v_d    = {1'b0, pick_x ? y_mv : x_mv};
`ifdef ENEMY_CHASER_DIAG_EN
                    if (x_mv && y_mv) begin
                        tgt_x_d    = nx;
                        tgt_y_d    = ny;
                        alt_x_d[0] = pick_x ? nx : cur_x_q;
                        alt_y_d[0] = pick_x ? cur_y_q : ny;
                        alt_x_d[1] = pick_x ? cur_x_q : nx;
                        alt_y_d[1] = pick_x ? ny : cur_y_q;
                        alt_v_d    = 2'b11;
                    end
`endif
                end
            end
            S_RD_TGT: state_d = S_CHK_TGT;
            S_CHK_TGT: begin
                if (grid_out == EMPTY) begin
                    state_d = S_WR_NEW;
                end else if (alt_v_q[0]) begin
                    tgt_x_d    = alt_x_q[0];
                    tgt_y_d    = alt_y_q[0];
                    alt_x_d[0] = alt_x_q[1];
                    alt_y_d[0] = alt_y_q[1];
                    alt_v_d    = {1'b0, alt_v_q[1]};
                    state_d    = S_RD_TGT;
                end else begin
                    state_d = S_ADV;
                end
            end
            S_WR_NEW: begin
                // Cells not yet scanned that now hold this enemy must be skipped
                if (tgt_x_q == cur_x_q + X_ONE && tgt_y_q == cur_y_q)
                    skip_nx_d = 1'b1;
                if (tgt_y_q == cur_y_q + Y_ONE)
                    down_mask_d[tgt_x_q] = 1'b1;
                state_d = S_WR_OLD;
            end
            S_WR_OLD: begin
                tally_d = tally_q + CNT_ONE;
                state_d = S_ADV;
            end
            S_ADV: begin
                if (cur_x_q == X_MAX && cur_y_q == Y_MAX) begin
                    moved_d = tally_q;
                    state_d = S_DONE;
                end else if (cur_x_q == X_MAX) begin
                    cur_x_d     = '0;
                    cur_y_d     = cur_y_q + Y_ONE;
                    cur_mask_d  = down_mask_q;
                    down_mask_d = '0;
                    skip_d      = 1'b0;
                    skip_nx_d   = 1'b0;
                    state_d     = S_RD_CUR;
                end else begin
                    cur_x_d   = cur_x_q + X_ONE;
                    skip_d    = skip_nx_q;
                    skip_nx_d = 1'b0;
                    state_d   = S_RD_CUR;
                end
            end
            S_DONE: begin
                cur_x_d = '0;
                cur_y_d = '0;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        // A tick in the acceptance cycle must not be lost
        if (tick_q == '0)
            pending_d = 1'b1;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= S_IDLE;
            tick_q      <= TICK_LAST;
            pending_q   <= 1'b0;
            cur_x_q     <= '0;
            cur_y_q     <= '0;
            tgt_x_q     <= '0;
            tgt_y_q     <= '0;
            alt_x_q     <= '0;
            alt_y_q     <= '0;
            alt_v_q     <= '0;
            skip_q      <= 1'b0;
            skip_nx_q   <= 1'b0;
            cur_mask_q  <= '0;
            down_mask_q <= '0;
            tally_q     <= '0;
            moved_q     <= '0;
        end else begin
            state_q     <= state_d;
            tick_q      <= tick_d;
            pending_q   <= pending_d;
            cur_x_q     <= cur_x_d;
            cur_y_q     <= cur_y_d;
            tgt_x_q     <= tgt_x_d;
            tgt_y_q     <= tgt_y_d;
            alt_x_q     <= alt_x_d;
            alt_y_q     <= alt_y_d;
            alt_v_q     <= alt_v_d;
            skip_q      <= skip_d;
            skip_nx_q   <= skip_nx_d;
            cur_mask_q  <= cur_mask_d;
            down_mask_q <= down_mask_d;
            tally_q     <= tally_d;
            moved_q     <= moved_d;
        end
    end

    always_comb begin
        busy        = state_q != S_IDLE;
        done        = state_q == S_DONE;
        grid_write  = (state_q == S_WR_NEW) || (state_q == S_WR_OLD);
        grid_in     = (state_q == S_WR_NEW) ? ENEMY :
                      (state_q == S_WR_OLD) ? EMPTY : '0;
        grid_x      = cur_x_q;
        grid_y      = cur_y_q;
        if (state_q == S_RD_TGT || state_q == S_WR_NEW) begin
            grid_x = tgt_x_q;
            grid_y = tgt_y_q;
        end
        moved_count = moved_q;
    end

endmodule

// File: tb/tb_enemy_chaser.sv
// Directed bench for enemy_chaser with a behavioural synchronous grid RAM.
// Expected writes are encoded as x*1000 + y*10 + cell.
module tb_enemy_chaser;

    localparam int TICK = 100;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic        done, busy, grid_write;
    logic [5:0]  player_x = '0;
    logic [4:0]  player_y = '0;
    logic [5:0]  grid_x;
    logic [4:0]  grid_y;
    logic [2:0]  grid_out = '0;
    logic [2:0]  grid_in;
    logic [10:0] moved_count;

    enemy_chaser #(.TICK_CYCLES(TICK)) dut (
        .clock(clock), .reset(reset), .start(start), .done(done),
        .busy(busy), .player_x(player_x), .player_y(player_y),
        .grid_x(grid_x), .grid_y(grid_y), .grid_out(grid_out),
        .grid_write(grid_write), .grid_in(grid_in),
        .moved_count(moved_count)
    );

    always #5 clock = ~clock;

    logic [2:0] mem [0:29][0:39];
    logic       tb_clr = 1'b0;
    logic       tb_ld = 1'b0;
    int         tb_lx = 0, tb_ly = 0;
    logic [2:0] tb_ld_d = '0;
    int         wlog[$];
    int         ndone = 0;
    int         passed = 0, total = 0;

    always @(posedge clock) begin
        if (grid_x < 6'd40 && grid_y < 5'd30)
            grid_out <= mem[grid_y][grid_x];
        if (tb_clr) begin
            for (int y = 0; y < 30; y++)
                for (int x = 0; x < 40; x++)
                    mem[y][x] <= 3'd0;
        end else if (tb_ld) begin
            mem[tb_ly][tb_lx] <= tb_ld_d;
        end else if (grid_write && grid_x < 6'd40 && grid_y < 5'd30) begin
            mem[grid_y][grid_x] <= grid_in;
        end
    end

    always @(posedge clock) begin
        if (grid_write)
            wlog.push_back(int'(grid_x) * 1000 + int'(grid_y) * 10 + int'(grid_in));
        if (done)
            ndone <= ndone + 1;
    end

    function automatic int ent(input int i);
        return (wlog.size() > i) ? wlog[i] : -1;
    endfunction

    task automatic do_reset();
        @(negedge clock) reset = 1'b1;
        repeat (2) @(negedge clock);
        reset = 1'b0;
    endtask

    task automatic clr_mem();
        @(negedge clock) tb_clr = 1'b1;
        @(negedge clock) tb_clr = 1'b0;
    endtask

    task automatic put(input int x, input int y, input logic [2:0] d);
        @(negedge clock);
        tb_ld = 1'b1; tb_lx = x; tb_ly = y; tb_ld_d = d;
        @(negedge clock) tb_ld = 1'b0;
    endtask

    task automatic wait_tick();
        repeat (TICK + 5) @(negedge clock);
    endtask

    // n = 1 on the first cycle after acceptance; poke re-raises start mid-sweep
    task automatic run_sweep(input int poke, output int n, output bit ok);
        @(negedge clock) start = 1'b1;
        @(negedge clock) start = 1'b0;
        n = 1;
        ok = 1'b0;
        while (n < 8000) begin
            start = (poke > 0 && n >= poke && n < poke + 4);
            if (done) begin
                ok = 1'b1;
                break;
            end
            @(negedge clock);
            n++;
        end
        start = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        reset = 1'b1;
        @(negedge clock);
        total++; if (done !== 1'b0) $display("FAIL rst_done: got %b want 0", done); else passed++;
        total++; if (busy !== 1'b0) $display("FAIL rst_busy: got %b want 0", busy); else passed++;
        total++; if (grid_write !== 1'b0) $display("FAIL rst_wr: got %b want 0", grid_write); else passed++;
        total++; if (grid_x !== 6'd0) $display("FAIL rst_gx: got %0d want 0", grid_x); else passed++;
        total++; if (grid_y !== 5'd0) $display("FAIL rst_gy: got %0d want 0", grid_y); else passed++;
        total++; if (grid_in !== 3'd0) $display("FAIL rst_gin: got %0d want 0", grid_in); else passed++;
        total++; if (moved_count !== 11'd0) $display("FAIL rst_moved: got %0d want 0", moved_count); else passed++;
        reset = 1'b0;
    endtask

    task automatic test_no_tick();
        int n; bit ok; int d0;
        clr_mem();
        put(5, 5, 3'd4);
        player_x = 6'd10; player_y = 5'd5;
        do_reset();
        wlog.delete();
        d0 = ndone;
        run_sweep(0, n, ok);
        total++; if (!ok) $display("FAIL notick_done: got timeout want done"); else passed++;
        total++; if (n !== 1) $display("FAIL notick_lat: got %0d want 1", n); else passed++;
        @(negedge clock);
        total++; if (busy !== 1'b0) $display("FAIL notick_busy: got %b want 0", busy); else passed++;
        repeat (5) @(negedge clock);
        total++; if (wlog.size() !== 0) $display("FAIL notick_writes: got %0d want 0", wlog.size()); else passed++;
        total++; if (moved_count !== 11'd0) $display("FAIL notick_moved: got %0d want 0", moved_count); else passed++;
        total++; if (ndone - d0 !== 1) $display("FAIL notick_pulses: got %0d want 1", ndone - d0); else passed++;
    endtask

    task automatic test_move_right();
        int n; bit ok; int d0;
        do_reset();
        clr_mem();
        put(5, 5, 3'd4);
        player_x = 6'd10; player_y = 5'd5;
        wait_tick();
        wlog.delete();
        d0 = ndone;
        run_sweep(0, n, ok);
        total++; if (!ok) $display("FAIL right_done: got timeout want done"); else passed++;
        total++; if (n !== 3605) $display("FAIL right_cycles: got %0d want 3605", n); else passed++;
        total++; if (moved_count !== 11'd1) $display("FAIL right_moved: got %0d want 1", moved_count); else passed++;
        @(negedge clock);
        total++; if (done !== 1'b0) $display("FAIL right_pulse: got %b want 0", done); else passed++;
        total++; if (wlog.size() !== 2) $display("FAIL right_nwr: got %0d want 2", wlog.size()); else passed++;
        total++; if (ent(0) !== 6054) $display("FAIL right_wr0: got %0d want 6054", ent(0)); else passed++;
        total++; if (ent(1) !== 5050) $display("FAIL right_wr1: got %0d want 5050", ent(1)); else passed++;
        total++; if (mem[5][6] !== 3'd4) $display("FAIL right_cell: got %0d want 4", mem[5][6]); else passed++;
        total++; if (ndone - d0 !== 1) $display("FAIL right_pulses: got %0d want 1", ndone - d0); else passed++;
    endtask

    task automatic test_back_to_back();
        int n; bit ok; int d0;
        wlog.delete();
        d0 = ndone;
        run_sweep(200, n, ok);
        repeat (3) @(negedge clock);
        total++; if (!ok) $display("FAIL b2b_done: got timeout want done"); else passed++;
        total++; if (n !== 3605) $display("FAIL b2b_cycles: got %0d want 3605", n); else passed++;
        total++; if (ndone - d0 !== 1) $display("FAIL b2b_pulses: got %0d want 1", ndone - d0); else passed++;
        total++; if (ent(0) !== 7054) $display("FAIL b2b_wr0: got %0d want 7054", ent(0)); else passed++;
        total++; if (ent(1) !== 6050) $display("FAIL b2b_wr1: got %0d want 6050", ent(1)); else passed++;
        total++; if (moved_count !== 11'd1) $display("FAIL b2b_moved: got %0d want 1", moved_count); else passed++;
    endtask

    task automatic test_wall();
        int n; bit ok;
        do_reset();
        clr_mem();
        put(3, 3, 3'd4);
        put(3, 4, 3'd1);
        player_x = 6'd3; player_y = 5'd10;
        wait_tick();
        wlog.delete();
        run_sweep(0, n, ok);
        total++; if (!ok) $display("FAIL wall_done: got timeout want done"); else passed++;
        total++; if (n !== 3603) $display("FAIL wall_cycles: got %0d want 3603", n); else passed++;
        total++; if (wlog.size() !== 0) $display("FAIL wall_writes: got %0d want 0", wlog.size()); else passed++;
        total++; if (moved_count !== 11'd0) $display("FAIL wall_moved: got %0d want 0", moved_count); else passed++;
        total++; if (mem[3][3] !== 3'd4) $display("FAIL wall_cell: got %0d want 4", mem[3][3]); else passed++;
    endtask

    task automatic test_fallback();
        int n; bit ok;
        do_reset();
        clr_mem();
        put(3, 3, 3'd4);
        put(4, 3, 3'd1);
        player_x = 6'd8; player_y = 5'd5;
        wait_tick();
        wlog.delete();
        run_sweep(0, n, ok);
        total++; if (!ok) $display("FAIL fb_done: got timeout want done"); else passed++;
        total++; if (n !== 3607) $display("FAIL fb_cycles: got %0d want 3607", n); else passed++;
        total++; if (wlog.size() !== 2) $display("FAIL fb_nwr: got %0d want 2", wlog.size()); else passed++;
        total++; if (ent(0) !== 3044) $display("FAIL fb_wr0: got %0d want 3044", ent(0)); else passed++;
        total++; if (ent(1) !== 3030) $display("FAIL fb_wr1: got %0d want 3030", ent(1)); else passed++;
        total++; if (moved_count !== 11'd1) $display("FAIL fb_moved: got %0d want 1", moved_count); else passed++;
    endtask

    task automatic test_pair();
        int n; bit ok;
        do_reset();
        clr_mem();
        put(0, 0, 3'd4);
        put(1, 0, 3'd4);
        player_x = 6'd39; player_y = 5'd0;
        wait_tick();
        wlog.delete();
        run_sweep(0, n, ok);
        total++; if (!ok) $display("FAIL pair_done: got timeout want done"); else passed++;
        total++; if (n !== 3607) $display("FAIL pair_cycles: got %0d want 3607", n); else passed++;
        total++; if (wlog.size() !== 2) $display("FAIL pair_nwr: got %0d want 2", wlog.size()); else passed++;
        total++; if (ent(0) !== 2004) $display("FAIL pair_wr0: got %0d want 2004", ent(0)); else passed++;
        total++; if (ent(1) !== 1000) $display("FAIL pair_wr1: got %0d want 1000", ent(1)); else passed++;
        total++; if (mem[0][0] !== 3'd4) $display("FAIL pair_stay: got %0d want 4", mem[0][0]); else passed++;
        total++; if (moved_count !== 11'd1) $display("FAIL pair_moved: got %0d want 1", moved_count); else passed++;
    endtask

    task automatic test_clamp();
        int n; bit ok;
        do_reset();
        clr_mem();
        put(39, 28, 3'd4);
        player_x = 6'd63; player_y = 5'd31;
        wait_tick();
        wlog.delete();
        run_sweep(0, n, ok);
        total++; if (!ok) $display("FAIL clamp_done: got timeout want done"); else passed++;
        total++; if (n !== 3605) $display("FAIL clamp_cycles: got %0d want 3605", n); else passed++;
        total++; if (wlog.size() !== 2) $display("FAIL clamp_nwr: got %0d want 2", wlog.size()); else passed++;
        total++; if (ent(0) !== 39294) $display("FAIL clamp_wr0: got %0d want 39294", ent(0)); else passed++;
        total++; if (ent(1) !== 39280) $display("FAIL clamp_wr1: got %0d want 39280", ent(1)); else passed++;
    endtask

    task automatic test_diag();
        int n; bit ok; int exp0;
`ifdef ENEMY_CHASER_DIAG_EN
        exp0 = 3034;
`else
        exp0 = 3024;
`endif
        do_reset();
        clr_mem();
        put(2, 2, 3'd4);
        player_x = 6'd6; player_y = 5'd6;
        wait_tick();
        wlog.delete();
        run_sweep(0, n, ok);
        total++; if (!ok) $display("FAIL diag_done: got timeout want done"); else passed++;
        total++; if (n !== 3605) $display("FAIL diag_cycles: got %0d want 3605", n); else passed++;
        total++; if (wlog.size() !== 2) $display("FAIL diag_nwr: got %0d want 2", wlog.size()); else passed++;
        total++; if (ent(0) !== exp0) $display("FAIL diag_wr0: got %0d want %0d", ent(0), exp0); else passed++;
        total++; if (ent(1) !== 2020) $display("FAIL diag_wr1: got %0d want 2020", ent(1)); else passed++;
    endtask

    task automatic test_reset_mid();
        int n;
        bit seen;
        do_reset();
        clr_mem();
        put(5, 5, 3'd4);
        player_x = 6'd10; player_y = 5'd5;
        wait_tick();
        wlog.delete();
        @(negedge clock) start = 1'b1;
        @(negedge clock) start = 1'b0;
        seen = 1'b0;
        for (n = 0; n < 8000; n++) begin
            if (grid_write) begin
                seen = 1'b1;
                break;
            end
            @(negedge clock);
        end
        total++; if (!seen) $display("FAIL mid_wrnew: got timeout want write"); else passed++;
        reset = 1'b1;
        @(negedge clock);
        total++; if (grid_write !== 1'b0) $display("FAIL mid_wr: got %b want 0", grid_write); else passed++;
        total++; if (busy !== 1'b0) $display("FAIL mid_busy: got %b want 0", busy); else passed++;
        total++; if (grid_x !== 6'd0) $display("FAIL mid_gx: got %0d want 0", grid_x); else passed++;
        total++; if (grid_in !== 3'd0) $display("FAIL mid_gin: got %0d want 0", grid_in); else passed++;
        reset = 1'b0;
        repeat (20) @(negedge clock);
        total++; if (wlog.size() !== 1) $display("FAIL mid_nwr: got %0d want 1", wlog.size()); else passed++;
        total++; if (mem[5][5] !== 3'd4) $display("FAIL mid_old: got %0d want 4", mem[5][5]); else passed++;
    endtask

    initial begin
        test_reset();
        test_no_tick();
        test_move_right();
        test_back_to_back();
        test_wall();
        test_fallback();
        test_pair();
        test_clamp();
        test_diag();
        test_reset_mid();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
